uart_rx_buffered: RTL

//  Parametrised UART receiver: oversampled serial-to-parallel conversion with runtime

---
 rtl/uart_rx_pkg.sv | 24 ++
 rtl/uart_rx_fifo.sv | 56 +++++
 rtl/uart_rx_buffered.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the buffered UART receiver.
// Optional build macro used by the receiver: UART_RX_MAJ_VOTE_EN.
package uart_rx_pkg;

  localparam int unsigned MIN_PRESCALE = 4;
  localparam int unsigned MAX_DATA_W   = 9;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    STOP2
  } rx_state_e;

  // Data is stored at the widest legal frame size; the top slices DATA_W bits.
  typedef struct packed {
    logic                  stp_err;
    logic                  par_err;
    logic [MAX_DATA_W-1:0] data;
  } rx_entry_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous receive FIFO: power-of-two depth, wrapping pointers,
// simultaneous push and pop allowed even when full.
module uart_rx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CNT_W = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  // When full, a push is only taken if the head is leaving in the same cycle.
  assign do_push = push_i & (~full_o | do_pop);
  assign rdata_o = mem_q[rd_ptr_q];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array write port.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_rx_buffered.sv
// Oversampled UART receiver with runtime parity/stop configuration,
// per-frame error flags and a receive FIFO with valid/ready pop.
// Build option: define UART_RX_MAJ_VOTE_EN for 3-sample majority voting.
module uart_rx_buffered
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned PRESCALE_W = 6,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [DATA_W-1:0]     P_DATA,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic                  overrun
);

  localparam int unsigned BIT_W   = $clog2(DATA_W);
  localparam int unsigned ENTRY_W = $bits(rx_entry_t);

  logic                  sync1_q, sync2_q, rx_prev_q;
  logic                  rx_s, fall;
  rx_state_e             state_q;
  logic [PRESCALE_W-1:0] ps_q, cnt_q, half, ps_d;
  logic [BIT_W-1:0]      bit_q;
  logic [DATA_W-1:0]     shift_q;
  logic                  par_en_q, par_typ_q, stop2_q;
  logic                  par_err_q, stp_err_q, overrun_q;
  logic                  bit_end, sample_hit, sample_bit, final_stop;
  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  rx_entry_t             push_entry, head_entry;
  logic [ENTRY_W-1:0]    fifo_rdata;
  logic                  unused_pad;

  assign rx_s    = sync2_q;
  assign fall    = rx_prev_q & ~sync2_q;
  assign half    = ps_q >> 1;
  assign bit_end = (cnt_q == ps_q - 1'b1);
  assign ps_d    = (prescale < PRESCALE_W'(MIN_PRESCALE)) ? PRESCALE_W'(MIN_PRESCALE) : prescale;

  // Two-flop synchroniser plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      sync1_q   <= RX_IN;
      sync2_q   <= sync1_q;
      rx_prev_q <= sync2_q;
    end
  end

`ifdef UART_RX_MAJ_VOTE_EN
  logic vote0_q, vote1_q;

  // Capture the two early samples; the decision is taken one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vote0_q <= 1'b1;
      vote1_q <= 1'b1;
    end else if (state_q != IDLE) begin
      if (cnt_q == half - 1'b1) vote0_q <= rx_s;
      if (cnt_q == half)        vote1_q <= rx_s;
    end
  end

  assign sample_hit = (state_q != IDLE) && (cnt_q == half + 1'b1);
  assign sample_bit = (vote0_q & vote1_q) | (vote0_q & rx_s) | (vote1_q & rx_s);
`else
  assign sample_hit = (state_q != IDLE) && (cnt_q == half);
  assign sample_bit = rx_s;
`endif

  assign final_stop = sample_hit &&
                      (((state_q == STOP) && !stop2_q) || (state_q == uart_rx_pkg::STOP2));

  assign push_entry.stp_err = stp_err_q | ~sample_bit;
  assign push_entry.par_err = par_err_q;
  assign push_entry.data    = MAX_DATA_W'(shift_q);

  assign fifo_push = final_stop;
  assign fifo_pop  = data_ready & ~fifo_empty;

  // Frame FSM, bit timer, shift register and error/overrun registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      ps_q      <= PRESCALE_W'(MIN_PRESCALE);
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      stop2_q   <= 1'b0;
      par_err_q <= 1'b0;
      stp_err_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= final_stop & fifo_full & ~fifo_pop;
      if (state_q != IDLE) cnt_q <= bit_end ? '0 : cnt_q + 1'b1;
      case (state_q)
        IDLE: begin
          if (fall) begin
            state_q   <= START;
            // The edge-detect cycle is bit-time 0, so the timer resumes at 1.
            cnt_q     <= PRESCALE_W'(1);
            bit_q     <= '0;
            par_err_q <= 1'b0;
            stp_err_q <= 1'b0;
            ps_q      <= ps_d;
            par_en_q  <= PAR_EN;
            par_typ_q <= PAR_TYP;
            stop2_q   <= STOP2;
          end
        end
        START: begin
          if (sample_hit && sample_bit) state_q <= IDLE;
          else if (bit_end)             state_q <= DATA;
        end
        DATA: begin
          if (sample_hit) shift_q <= {sample_bit, shift_q[DATA_W-1:1]};
          if (bit_end) begin
            if (bit_q == BIT_W'(DATA_W - 1)) begin
              bit_q   <= '0;
              state_q <= par_en_q ? PARITY : STOP;
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end
        end
        PARITY: begin
          if (sample_hit) par_err_q <= sample_bit != ((^shift_q) ^ par_typ_q);
          if (bit_end)    state_q   <= STOP;
        end
        STOP: begin
          if (sample_hit) stp_err_q <= stp_err_q | ~sample_bit;
          if (sample_hit && !stop2_q) state_q <= IDLE;
          else if (bit_end)           state_q <= uart_rx_pkg::STOP2;
        end
        uart_rx_pkg::STOP2: begin
          if (sample_hit) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  uart_rx_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i (push_entry),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign head_entry = rx_entry_t'(fifo_rdata);
  assign unused_pad = ^head_entry.data;

  // Head outputs are forced to zero while the FIFO is empty.
  assign data_valid = ~fifo_empty;
  assign P_DATA     = data_valid ? head_entry.data[DATA_W-1:0] : '0;
  assign par_err    = data_valid & head_entry.par_err;
  assign stp_err    = data_valid & head_entry.stp_err;
  assign overrun    = overrun_q;

endmodule
